fight_arena_core: RTL
=====================

Name: fight_arena_core

Overview:
- Parametrised successor of the two-player fighting-game logic core.
- Resolves one turn per enabled clock: movement, punch/kick, jump evasion and HP tracking for two players on a one-hot position track.
- Adds over the previous generation: configurable HP width, track length and damage, per-action cooldowns, turn-limit timeout and winner/game-over reporting.
- Sits between the debounced player button inputs and the LED/7-seg display drivers.

Parameters:
- HP_W, 2: HP register width; HP_MAX = 2^HP_W-1. Legal: ≥1.
- NPOS, 3: track cells. Legal: ≥2.
- PUNCH_DMG, 1: punch damage. Legal: 1..HP_MAX.
- KICK_DMG, 2: kick damage. Legal: 1..HP_MAX.
- JUMP_CD, 2: turns jump is suppressed after an effective jump.
- KICK_CD, 1: turns kick is suppressed after an effective kick.
- TURN_LIMIT, 16: enabled turns before timeout; 0 disables timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  turn enable; when 0, all state holds.
- act1  in  6  player 1 buttons {right,left,jump,wait,kick,punch}, bit0 = punch.
- act2  in  6  player 2 buttons, same encoding.
- hp1  out  HP_W  player 1 HP.
- hp2  out  HP_W  player 2 HP.
- pos1  out  NPOS  player 1 position, one-hot, bit0 = leftmost cell.
- pos2  out  NPOS  player 2 position, one-hot.
- game_over  out  1  match finished.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

Behaviour:
- Reset (async, immediate):
  - hp1 = hp2 = HP_MAX; p1 = 0; p2 = NPOS-1.
  - Cooldown counters = 0; turn counter = 0.
  - game_over = 0; winner = 00.
- States: PLAY, OVER.
  - OVER holds all outputs and ignores act/en until reset.
- Turn: on a rising clk with en=1 in PLAY, act1/act2 are sampled and resolved. All outputs are registered and show the result after that edge (latency 1).
- Action decode per player:
  - Lowest set bit wins (punch > kick > wait > jump > left > right).
  - No bits set = wait.
  - Jump while the jump cooldown ≠ 0 → wait.
  - Kick while the kick cooldown ≠ 0 → wait.
- Distance: d = p2 - p1, taken from start-of-turn positions. The invariant p1 < p2 always holds.
- Attacks:
  - Punch hits if d == 1; kick hits if d ≤ 2.
  - A target whose effective action is jump takes no damage this turn.
  - A target moving this turn is still hit.
  - Simultaneous attacks both apply.
- Damage: hp_new = (hp > dmg) ? hp - dmg : 0. HP saturates at 0 and never wraps.
- Movement:
  - Candidate n = p ± 1, clamped to 0..NPOS-1.
  - If n1 ≥ n2 (collision or crossing), both players keep their old positions.
  - Otherwise both moves apply.
  - An attacking player does not move.
- Cooldowns:
  - An effective jump loads the jump counter with JUMP_CD.
  - An effective kick loads the kick counter with KICK_CD.
  - Otherwise a nonzero counter decrements by 1 per enabled turn.
- Turn counter:
  - Increments per enabled PLAY turn and saturates at TURN_LIMIT.
  - Width is clog2(TURN_LIMIT+1), minimum 1.
- End conditions, evaluated on post-turn values:
  - If either HP = 0: OVER, game_over = 1. winner = 01 if only hp2 = 0, 10 if only hp1 = 0, 11 if both are 0.
  - Else, if TURN_LIMIT ≠ 0 and the counter reaches TURN_LIMIT: OVER. Higher HP wins; equal HP → 11.
  - A KO takes precedence over timeout on the same turn.
- en=0: no change to any register, including cooldowns and the turn counter.
- A reset asserted mid-turn or in OVER restores reset values asynchronously. The first turn after deassertion resolves normally.

Test Plan (defaults unless noted):
- Reset: assert, then release → hp1 = hp2 = 3, pos1 = 001, pos2 = 100, game_over = 0, winner = 00.
- Collision: act1 = right, act2 = left at p = 0/2 → both candidates are 1, positions unchanged. Then act1 = right alone → pos1 = 010.
- Jump and cooldown: at d = 1, punch1 + jump2 → hp2 = 3. Next turn punch1 + jump2 → jump suppressed, hp2 = 2.
- Trade and hold: at d = 1, punch1 + punch2 → hp1 = hp2 = 2. Then en = 0 with any inputs for 5 clocks → no change.
- KO:
  - At d = 2, kick1 → hp2 = 1.
  - Next turn kick1 → wait (cooldown), hp2 = 1.
  - Following turn kick1 → hp2 = 0, game_over = 1, winner = 01.
  - Further inputs are ignored until reset.
- Timeout: TURN_LIMIT = 4, four enabled wait turns → game_over on the 4th edge, winner = 11. Async reset mid-turn → immediate reset values.

Source files
------------

// File: rtl/fight_arena_core.sv
// Two-player fighting-game turn resolver: movement, punch/kick, jump evasion,
// per-action cooldowns, HP tracking and KO/timeout winner reporting.
module fight_arena_core #(
    parameter int HP_W       = 2,
    parameter int NPOS       = 3,
    parameter int PUNCH_DMG  = 1,
    parameter int KICK_DMG   = 2,
    parameter int JUMP_CD    = 2,
    parameter int KICK_CD    = 1,
    parameter int TURN_LIMIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [5:0]      act1,
    input  logic [5:0]      act2,
    output logic [HP_W-1:0] hp1,
    output logic [HP_W-1:0] hp2,
    output logic [NPOS-1:0] pos1,
    output logic [NPOS-1:0] pos2,
    output logic            game_over,
    output logic [1:0]      winner
);

    localparam int PW = (NPOS > 1) ? $clog2(NPOS) : 1;
    localparam int TW = (TURN_LIMIT > 0) ? $clog2(TURN_LIMIT + 1) : 1;
    localparam int JW = (JUMP_CD > 0) ? $clog2(JUMP_CD + 1) : 1;
    localparam int KW = (KICK_CD > 0) ? $clog2(KICK_CD + 1) : 1;

    localparam logic [HP_W-1:0] HP_MAX = {HP_W{1'b1}};
    localparam logic [HP_W-1:0] PD     = HP_W'(PUNCH_DMG);
    localparam logic [HP_W-1:0] KD     = HP_W'(KICK_DMG);
    localparam logic [PW-1:0]   LAST   = PW'(NPOS - 1);
    localparam logic [TW-1:0]   TL     = TW'(TURN_LIMIT);
    localparam logic [JW-1:0]   JC     = JW'(JUMP_CD);
    localparam logic [KW-1:0]   KC     = KW'(KICK_CD);

    typedef enum logic [2:0] {
        A_PUNCH = 3'd0,
        A_KICK  = 3'd1,
        A_WAIT  = 3'd2,
        A_JUMP  = 3'd3,
        A_LEFT  = 3'd4,
        A_RIGHT = 3'd5
    } act_e;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_e;

    // Lowest set bit wins; an action still on cooldown degrades to wait.
    function automatic act_e decode(input logic [5:0] a, input logic jump_ok, input logic kick_ok);
        act_e r;
        r = A_WAIT;
        if (a[0]) begin
            r = A_PUNCH;
        end else if (a[1]) begin
            r = kick_ok ? A_KICK : A_WAIT;
        end else if (a[2]) begin
            r = A_WAIT;
        end else if (a[3]) begin
            r = jump_ok ? A_JUMP : A_WAIT;
        end else if (a[4]) begin
            r = A_LEFT;
        end else if (a[5]) begin
            r = A_RIGHT;
        end else begin
            r = A_WAIT;
        end
        return r;
    endfunction

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp, input logic [HP_W-1:0] dmg);
        return (hp > dmg) ? (hp - dmg) : {HP_W{1'b0}};
    endfunction

    function automatic logic [NPOS-1:0] onehot(input logic [PW-1:0] idx);
        logic [NPOS-1:0] r;
        r      = {NPOS{1'b0}};
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [PW-1:0] step(input logic [PW-1:0] p, input act_e a);
        logic [PW-1:0] r;
        r = p;
        case (a)
            A_LEFT:  r = (p != {PW{1'b0}}) ? (p - PW'(1)) : p;
            A_RIGHT: r = (p != LAST) ? (p + PW'(1)) : p;
            default: r = p;
        endcase
        return r;
    endfunction

    state_e          state_r, state_next_s;
    logic [HP_W-1:0] hp1_r, hp2_r, hp1_next_s, hp2_next_s;
    logic [PW-1:0]   p1_r, p2_r, p1_next_s, p2_next_s, n1_s, n2_s;
    logic [NPOS-1:0] pos1_r, pos2_r;
    logic [JW-1:0]   jcd1_r, jcd2_r, jcd1_next_s, jcd2_next_s;
    logic [KW-1:0]   kcd1_r, kcd2_r, kcd1_next_s, kcd2_next_s;
    logic [TW-1:0]   tc_r, tc_next_s;
    logic            game_over_r;
    logic [1:0]      winner_r, winner_next_s;
    logic [PW:0]     d_s;
    logic [HP_W-1:0] dmg1_s, dmg2_s;
    logic            ko1_s, ko2_s, timeout_s;
    act_e            a1_s, a2_s;

    // State and datapath registers; only enabled PLAY turns update the datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= PLAY;
            hp1_r       <= HP_MAX;
            hp2_r       <= HP_MAX;
            p1_r        <= {PW{1'b0}};
            p2_r        <= LAST;
            pos1_r      <= {{(NPOS-1){1'b0}}, 1'b1};
            pos2_r      <= {1'b1, {(NPOS-1){1'b0}}};
            jcd1_r      <= {JW{1'b0}};
            jcd2_r      <= {JW{1'b0}};
            kcd1_r      <= {KW{1'b0}};
            kcd2_r      <= {KW{1'b0}};
            tc_r        <= {TW{1'b0}};
            game_over_r <= 1'b0;
            winner_r    <= 2'b00;
        end else begin
            state_r <= state_next_s;
            if (en && (state_r == PLAY)) begin
                hp1_r       <= hp1_next_s;
                hp2_r       <= hp2_next_s;
                p1_r        <= p1_next_s;
                p2_r        <= p2_next_s;
                pos1_r      <= onehot(p1_next_s);
                pos2_r      <= onehot(p2_next_s);
                jcd1_r      <= jcd1_next_s;
                jcd2_r      <= jcd2_next_s;
                kcd1_r      <= kcd1_next_s;
                kcd2_r      <= kcd2_next_s;
                tc_r        <= tc_next_s;
                game_over_r <= (state_next_s == OVER);
                winner_r    <= winner_next_s;
            end
        end
    end

    // Turn resolution from start-of-turn positions, HP and cooldowns.
    always_comb begin
        a1_s = decode(act1, (jcd1_r == {JW{1'b0}}), (kcd1_r == {KW{1'b0}}));
        a2_s = decode(act2, (jcd2_r == {JW{1'b0}}), (kcd2_r == {KW{1'b0}}));
        d_s  = {1'b0, p2_r} - {1'b0, p1_r};

        dmg2_s = {HP_W{1'b0}};
        if ((a1_s == A_PUNCH) && (d_s == (PW+1)'(1))) begin
            dmg2_s = PD;
        end else if ((a1_s == A_KICK) && (d_s <= (PW+1)'(2))) begin
            dmg2_s = KD;
        end else begin
            dmg2_s = {HP_W{1'b0}};
        end
        dmg1_s = {HP_W{1'b0}};
        if ((a2_s == A_PUNCH) && (d_s == (PW+1)'(1))) begin
            dmg1_s = PD;
        end else if ((a2_s == A_KICK) && (d_s <= (PW+1)'(2))) begin
            dmg1_s = KD;
        end else begin
            dmg1_s = {HP_W{1'b0}};
        end
        hp1_next_s = (a1_s == A_JUMP) ? hp1_r : sat_sub(hp1_r, dmg1_s);
        hp2_next_s = (a2_s == A_JUMP) ? hp2_r : sat_sub(hp2_r, dmg2_s);

        // Collision or crossing cancels both moves.
        n1_s = step(p1_r, a1_s);
        n2_s = step(p2_r, a2_s);
        if (n1_s >= n2_s) begin
            p1_next_s = p1_r;
            p2_next_s = p2_r;
        end else begin
            p1_next_s = n1_s;
            p2_next_s = n2_s;
        end

        jcd1_next_s = (a1_s == A_JUMP) ? JC : ((jcd1_r != {JW{1'b0}}) ? (jcd1_r - JW'(1)) : jcd1_r);
        jcd2_next_s = (a2_s == A_JUMP) ? JC : ((jcd2_r != {JW{1'b0}}) ? (jcd2_r - JW'(1)) : jcd2_r);
        kcd1_next_s = (a1_s == A_KICK) ? KC : ((kcd1_r != {KW{1'b0}}) ? (kcd1_r - KW'(1)) : kcd1_r);
        kcd2_next_s = (a2_s == A_KICK) ? KC : ((kcd2_r != {KW{1'b0}}) ? (kcd2_r - KW'(1)) : kcd2_r);

        tc_next_s = (tc_r == TL) ? tc_r : (tc_r + TW'(1));
        ko1_s     = (hp1_next_s == {HP_W{1'b0}});
        ko2_s     = (hp2_next_s == {HP_W{1'b0}});
        timeout_s = (TURN_LIMIT != 0) && (tc_next_s == TL);
    end

    // Next-state logic: PLAY ends on KO or timeout; OVER holds until reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            PLAY: begin
                if (en && (ko1_s || ko2_s || timeout_s)) begin
                    state_next_s = OVER;
                end else begin
                    state_next_s = PLAY;
                end
            end
            OVER:    state_next_s = OVER;
            default: state_next_s = PLAY;
        endcase
    end

    // Winner encoding for the turn being resolved; KO outranks timeout.
    always_comb begin
        winner_next_s = 2'b00;
        if (ko1_s && ko2_s) begin
            winner_next_s = 2'b11;
        end else if (ko2_s) begin
            winner_next_s = 2'b01;
        end else if (ko1_s) begin
            winner_next_s = 2'b10;
        end else if (timeout_s) begin
            if (hp1_next_s > hp2_next_s) begin
                winner_next_s = 2'b01;
            end else if (hp2_next_s > hp1_next_s) begin
                winner_next_s = 2'b10;
            end else begin
                winner_next_s = 2'b11;
            end
        end else begin
            winner_next_s = 2'b00;
        end
    end

    assign hp1       = hp1_r;
    assign hp2       = hp2_r;
    assign pos1      = pos1_r;
    assign pos2      = pos2_r;
    assign game_over = game_over_r;
    assign winner    = winner_r;

endmodule
